basemul_acc_sched: RTL and testbench

Scheduler that sequences the basemul/tomont core over K polynomial pairs to form one row of the Kyber polyvec pointwise product (A-row · s). For each pair it requests an operand load, fires the core, and waits for completion. It tells the downstream accumulator whether the current product overwrites or adds. It sits between the top-level keygen/encrypt control and the basemul core plus its operand loader.

---
 rtl/basemul_acc_sched_if.sv | 26 ++
 rtl/basemul_acc_sched.sv | 169 ++++++++++++++++
 tb/tb_basemul_acc_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/basemul_acc_sched_if.sv
// Handshake bundle between row control, the basemul core/loader and the
// pointwise-product scheduler. master = controller/core side, slave = scheduler.
interface basemul_acc_sched_if;
    logic       start;
    logic       abort;
    logic [2:0] k_num;
    logic       ld_req;
    logic [1:0] ld_idx;
    logic       ld_ack;
    logic       cal_en;
    logic       core_done;
    logic       acc_first;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, abort, k_num, ld_ack, core_done,
        input  ld_req, ld_idx, cal_en, acc_first, busy, done, err
    );

    modport slave (
        input  start, abort, k_num, ld_ack, core_done,
        output ld_req, ld_idx, cal_en, acc_first, busy, done, err
    );
endinterface

// File: rtl/basemul_acc_sched.sv
// Sequences load -> basemul/tomont -> accumulate over the K pairs of one
// polyvec row; every output is a flop loaded from the next-state decode.
module basemul_acc_sched #(
    parameter int KMAX    = 4,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    basemul_acc_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_LD  = 3'd2,
        S_CALC     = 3'd3,
        S_WAIT_CAL = 3'd4,
        S_NEXT     = 3'd5,
        S_FIN      = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WDOG_MAX  = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] WDOG_ONE  = TO_W'(1);
    localparam logic [2:0]      K_MIN     = 3'd2;
    localparam logic [2:0]      K_MAX     = 3'(KMAX);

    state_t            state_r, state_s;
    logic [1:0]        idx_r, idx_s;
    logic [2:0]        k_r, k_s;
    logic [TO_W-1:0]   wdog_r, wdog_s;
    logic              err_r, err_s;
    logic              ld_req_r, cal_en_r, acc_first_r, busy_r, done_r;
    logic [1:0]        ld_idx_r;

    function automatic logic k_valid(input logic [2:0] k);
        return (k >= K_MIN) && (k <= K_MAX);
    endfunction

    // Saturating step so a long wait can never wrap back to zero.
    function automatic logic [TO_W-1:0] wdog_inc(input logic [TO_W-1:0] w);
        return (w == WDOG_MAX) ? w : (w + WDOG_ONE);
    endfunction

    function automatic logic in_row(input state_t s);
        return (s == S_LOAD) || (s == S_WAIT_LD) || (s == S_CALC) ||
               (s == S_WAIT_CAL) || (s == S_NEXT);
    endfunction

    // Next-state, index, watchdog and error-flag decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        k_s     = k_r;
        wdog_s  = wdog_r;
        err_s   = err_r;
        if (bus.abort) begin
            state_s = S_IDLE;
            idx_s   = 2'd0;
            if (state_r == S_ERR) begin
                err_s = 1'b0;
            end else begin
                err_s = err_r;
            end
        end else begin
            case (state_r)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        if (k_valid(bus.k_num)) begin
                            state_s = S_LOAD;
                            k_s     = bus.k_num;
                            idx_s   = 2'd0;
                            err_s   = 1'b0;
                        end else begin
                            state_s = S_ERR;
                            err_s   = 1'b1;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                S_LOAD: begin
                    state_s = S_WAIT_LD;
                    wdog_s  = {TO_W{1'b0}};
                end
                S_WAIT_LD: begin
                    if (bus.ld_ack) begin
                        state_s = S_CALC;
                    end else if (wdog_r == WDOG_LAST) begin
                        state_s = S_ERR;
                        err_s   = 1'b1;
                    end else begin
                        wdog_s = wdog_inc(wdog_r);
                    end
                end
                S_CALC: begin
                    state_s = S_WAIT_CAL;
                    wdog_s  = {TO_W{1'b0}};
                end
                S_WAIT_CAL: begin
                    if (bus.core_done) begin
                        state_s = S_NEXT;
                    end else if (wdog_r == WDOG_LAST) begin
                        state_s = S_ERR;
                        err_s   = 1'b1;
                    end else begin
                        wdog_s = wdog_inc(wdog_r);
                    end
                end
                S_NEXT: begin
                    if ({1'b0, idx_r} == (k_r - 3'd1)) begin
                        state_s = S_FIN;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = S_LOAD;
                    end
                end
                S_FIN: begin
                    state_s = S_IDLE;
                    idx_s   = 2'd0;
                end
                default: begin
                    state_s = S_IDLE;
                    idx_s   = 2'd0;
                end
            endcase
        end
    end

    // State registers plus output flops decoded from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            idx_r       <= 2'd0;
            k_r         <= 3'd0;
            wdog_r      <= {TO_W{1'b0}};
            err_r       <= 1'b0;
            ld_req_r    <= 1'b0;
            cal_en_r    <= 1'b0;
            acc_first_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ld_idx_r    <= 2'd0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            k_r         <= k_s;
            wdog_r      <= wdog_s;
            err_r       <= err_s;
            ld_req_r    <= (state_s == S_LOAD);
            cal_en_r    <= (state_s == S_CALC);
            done_r      <= (state_s == S_FIN);
            busy_r      <= (state_s != S_IDLE) && (state_s != S_ERR);
            acc_first_r <= in_row(state_s) && (idx_s == 2'd0);
            ld_idx_r    <= idx_s;
        end
    end

    assign bus.ld_req    = ld_req_r;
    assign bus.ld_idx    = ld_idx_r;
    assign bus.cal_en    = cal_en_r;
    assign bus.acc_first = acc_first_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_basemul_acc_sched.sv
// Scoreboard bench: each row's expected event timeline (load, calc, done, error)
// is computed from per-pair delays and checked by a monitor as events occur.
module tb_basemul_acc_sched;

    localparam int KMAX    = 4;
    localparam int TO_W    = 10;
    localparam int TIMEOUT = 16;

    localparam int EV_LD   = 0;
    localparam int EV_CAL  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    ev_t  exp_q[$];
    int   dl_arr[KMAX];
    int   dc_arr[KMAX];
    bit   model_err;
    logic ack_ld, ack_cd, stray_ld, stray_cd;
    int   ld_cnt, cd_cnt;

    basemul_acc_sched_if bus ();

    basemul_acc_sched #(.KMAX(KMAX), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    assign bus.ld_ack    = ack_ld | stray_ld;
    assign bus.core_done = ack_cd | stray_cd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core/loader stand-in: answers ld_req / cal_en after the per-pair delay (0 = never).
    initial begin
        ack_ld = 1'b0; ack_cd = 1'b0; ld_cnt = 0; cd_cnt = 0;
        forever begin
            @(negedge clk);
            ack_ld = 1'b0;
            ack_cd = 1'b0;
            if (ld_cnt > 0) begin ld_cnt--; if (ld_cnt == 0) ack_ld = 1'b1; end
            if (cd_cnt > 0) begin cd_cnt--; if (cd_cnt == 0) ack_cd = 1'b1; end
            if (reset) begin
                ld_cnt = 0; cd_cnt = 0;
            end else begin
                if (bus.ld_req) ld_cnt = dl_arr[bus.ld_idx];
                if (bus.cal_en) cd_cnt = dc_arr[bus.ld_idx];
            end
        end
    end

    function automatic logic [7:0] out_vec();
        return {bus.ld_req, bus.ld_idx, bus.cal_en, bus.acc_first, bus.busy, bus.done, bus.err};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input int kind);
        ev_t e;
        bit  ok;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d idx=%0d at cyc %0d, required none",
                     kind, bus.ld_idx, cyc);
            return;
        end
        e  = exp_q.pop_front();
        ok = (kind == e.kind) && (cyc == e.cyc) && (int'(bus.ld_idx) == e.idx);
        case (kind)
            EV_LD, EV_CAL: ok = ok && (bus.acc_first == (e.idx == 0)) && bus.busy && !bus.err;
            EV_DONE:       ok = ok && bus.busy && !bus.acc_first && !bus.err;
            default:       ok = ok && !bus.busy && !bus.acc_first;
        endcase
        if (!ok) begin
            n_bad++;
            $display("FAIL event: got kind=%0d idx=%0d cyc=%0d af=%0b busy=%0b err=%0b, required kind=%0d idx=%0d cyc=%0d",
                     kind, bus.ld_idx, cyc, bus.acc_first, bus.busy, bus.err, e.kind, e.idx, e.cyc);
        end
    endtask

    task automatic push(input int kind, input int idx, input int t);
        ev_t e;
        e.kind = kind; e.idx = idx; e.cyc = t;
        exp_q.push_back(e);
    endtask

    task automatic set_delays(input int a0, input int a1, input int a2, input int a3,
                              input int c0, input int c1, input int c2, input int c3);
        dl_arr[0] = a0; dl_arr[1] = a1; dl_arr[2] = a2; dl_arr[3] = a3;
        dc_arr[0] = c0; dc_arr[1] = c1; dc_arr[2] = c2; dc_arr[3] = c3;
    endtask

    // Pulse start and predict the whole timeline: pair p costs 3 + load delay + calc delay
    // cycles, the row ends with one FIN cycle; a withheld reply times out after TIMEOUT cycles.
    task automatic begin_row(input int k, input bit expect_to);
        int n, off, t_ld, t_cal;
        bit held;
        @(posedge clk); #1;
        bus.k_num = k[2:0];
        bus.start = 1'b1;
        n = cyc;
        if (k < 2 || k > KMAX) begin
            if (!model_err) push(EV_ERR, 0, n + 1);
            model_err = 1'b1;
        end else begin
            model_err = 1'b0;
            off  = 0;
            held = 1'b0;
            for (int p = 0; p < k && !held; p++) begin
                t_ld = n + off + 1;
                push(EV_LD, p, t_ld);
                if (dl_arr[p] == 0) begin
                    held = 1'b1;
                    if (expect_to) begin push(EV_ERR, p, t_ld + TIMEOUT + 1); model_err = 1'b1; end
                end else begin
                    t_cal = t_ld + 1 + dl_arr[p];
                    push(EV_CAL, p, t_cal);
                    if (dc_arr[p] == 0) begin
                        held = 1'b1;
                        if (expect_to) begin push(EV_ERR, p, t_cal + TIMEOUT + 1); model_err = 1'b1; end
                    end
                    off += 3 + dl_arr[p] + dc_arr[p];
                end
            end
            if (!held) push(EV_DONE, k - 1, n + off + 1);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_row(input string name, input int k, input bit expect_to);
        begin_row(k, expect_to);
        drain(name);
        if (k < 2 || k > KMAX) check({name, "_busy_err"}, {30'd0, bus.busy, bus.err}, 1);
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1; bus.abort = 1'b1;
        @(posedge clk); #1; bus.abort = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit err_prev, busy_next;
        int k;
        n_cmp = 0; n_bad = 0; cyc = 0; model_err = 1'b0;
        reset = 1'b0; stray_ld = 1'b0; stray_cd = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.k_num = 3'd0;
        set_delays(1, 1, 1, 1, 1, 1, 1, 1);
        err_prev = 1'b0; busy_next = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (busy_next) begin
                    check("busy_after_done", {30'd0, bus.busy, bus.done}, 0);
                    busy_next = 1'b0;
                end
                if (bus.ld_req) observe(EV_LD);
                if (bus.cal_en) observe(EV_CAL);
                if (bus.done) begin observe(EV_DONE); busy_next = 1'b1; end
                if (bus.err && !err_prev) observe(EV_ERR);
                err_prev = bus.err;
            end
        join_none

        #2 reset = 1'b1;
        #1 check("reset_outputs", out_vec(), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", out_vec(), 0);

        // Test 1: k=3, loads answered after 2 cycles, calcs after 4.
        set_delays(2, 2, 2, 2, 4, 4, 4, 4);
        run_row("t1_k3", 3, 1'b0);

        // Test 2: k=2 with immediate replies, done 11 cycles after start.
        set_delays(1, 1, 1, 1, 1, 1, 1, 1);
        run_row("t2_k2", 2, 1'b0);

        // Test 3: invalid k then a full 4-pair row clears err.
        run_row("t3_k5", 5, 1'b0);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", {30'd0, bus.busy, bus.err}, 1);
        set_delays(1, 2, 1, 3, 2, 1, 3, 1);
        run_row("t3_k4", 4, 1'b0);
        check("t3_err_cleared", bus.err, 0);

        // Test 4: core_done withheld for pair 1 -> watchdog error, no done.
        set_delays(1, 1, 1, 1, 1, 0, 1, 1);
        run_row("t4_timeout", 2, 1'b1);
        check("t4_err", {30'd0, bus.busy, bus.err}, 1);
        pulse_abort();
        model_err = 1'b0;
        @(negedge clk);
        check("t4_abort_in_err", out_vec(), 0);

        // Randomized rows, including out-of-range k.
        for (int r = 0; r < 10; r++) begin
            k = $urandom_range(0, 7);
            for (int p = 0; p < KMAX; p++) begin
                dl_arr[p] = $urandom_range(1, 6);
                dc_arr[p] = $urandom_range(1, 6);
            end
            run_row("rand_row", k, 1'b0);
        end

        // Test 5: abort in WAIT_CAL of pair 1, stray replies ignored, then a clean row.
        set_delays(1, 1, 1, 1, 2, 0, 1, 1);
        begin_row(4, 1'b0);
        drain("t5_pre_abort");
        pulse_abort();
        @(negedge clk);
        check("t5_abort_idle", out_vec(), 0);
        stray_cd = 1'b1; stray_ld = 1'b1;
        @(negedge clk);
        stray_cd = 1'b0; stray_ld = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_stray_ignored", out_vec(), 0);
        set_delays(1, 1, 1, 1, 1, 1, 1, 1);
        run_row("t5_k2", 2, 1'b0);

        // Test 6a: a second start mid-row must not disturb the running row.
        set_delays(2, 1, 3, 1, 1, 3, 2, 1);
        begin_row(3, 1'b0);
        repeat (6) @(posedge clk);
        #1 bus.k_num = 3'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        drain("t6_restart");

        // Test 6b: async reset while stuck in WAIT_LD.
        set_delays(0, 1, 1, 1, 1, 1, 1, 1);
        begin_row(2, 1'b0);
        drain("t6_pre_reset");
        @(posedge clk); #3 reset = 1'b1;
        #1 check("t6_reset_midrow", out_vec(), 0);
        model_err = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_after_reset", out_vec(), 0);
        set_delays(1, 1, 1, 1, 1, 1, 1, 1);
        run_row("t6_k3", 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
